frog_sprite_engine: RTL

//  Parametrised VGA timing generator plus one movable rectangular sprite (the frog).

---
 rtl/frog_sprite_engine.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/frog_sprite_engine.sv
// VGA timing generator with one movable rectangular sprite, moved only at frame boundaries.
// Optional build macro SPRITE_WRAP_EN: sprite wraps at screen edges instead of clamping.
module frog_sprite_engine #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_PULSE     = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_PULSE     = 2,
  parameter int V_BACK      = 33,
  parameter int SPRITE_W    = 50,
  parameter int SPRITE_H    = 40,
  parameter int STEP_PX     = 2,
  parameter int STEP_FRAMES = 1,
  parameter int COLOR_BITS  = 3,
  parameter logic [3*COLOR_BITS-1:0] FG_RGB = '1,
  parameter logic [3*COLOR_BITS-1:0] BG_RGB = {{COLOR_BITS{1'b1}}, {(2*COLOR_BITS){1'b0}}}
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BTN_UP,
  input  logic                  BTN_DOWN,
  input  logic                  BTN_LEFT,
  input  logic                  BTN_RIGHT,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic [COLOR_BITS-1:0] VGA_R,
  output logic [COLOR_BITS-1:0] VGA_G,
  output logic [COLOR_BITS-1:0] VGA_B,
  output logic [9:0]            SPRITE_X,
  output logic [9:0]            SPRITE_Y,
  output logic                  FRAME_START
);

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_PULSE + V_BACK;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_UPD  = VW'(V_DISPLAY - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_DISPLAY);
  localparam logic [VW-1:0] V_VIS  = VW'(V_DISPLAY);
  localparam logic [HW-1:0] HS_BEG = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_DISPLAY + H_FRONT + H_PULSE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_DISPLAY + V_FRONT + V_PULSE);
  localparam logic [FW-1:0] F_LAST = FW'(STEP_FRAMES - 1);

  localparam logic [10:0] X_MAX = 11'(H_DISPLAY - SPRITE_W);
  localparam logic [10:0] Y_MAX = 11'(V_DISPLAY - SPRITE_H);
  localparam logic [10:0] STEP  = 11'(STEP_PX);
  localparam logic [10:0] SW    = 11'(SPRITE_W);
  localparam logic [10:0] SH    = 11'(SPRITE_H);
  localparam logic [9:0]  X_INIT = 10'((H_DISPLAY - SPRITE_W) / 2);
  localparam logic [9:0]  Y_INIT = 10'((V_DISPLAY - SPRITE_H) / 2);

  // Position taken when a step would leave the screen past the low / high edge.
`ifdef SPRITE_WRAP_EN
  localparam logic [9:0] X_PAST_LO = 10'(X_MAX);
  localparam logic [9:0] X_PAST_HI = 10'd0;
  localparam logic [9:0] Y_PAST_LO = 10'(Y_MAX);
  localparam logic [9:0] Y_PAST_HI = 10'd0;
`else
  localparam logic [9:0] X_PAST_LO = 10'd0;
  localparam logic [9:0] X_PAST_HI = 10'(X_MAX);
  localparam logic [9:0] Y_PAST_LO = 10'd0;
  localparam logic [9:0] Y_PAST_HI = 10'(Y_MAX);
`endif

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [FW-1:0] frame_cnt;
  logic [3:0]    btn_meta;
  logic [3:0]    btn_sync;   // {up, down, left, right}
  logic [10:0]   x_w;
  logic [10:0]   y_w;
  logic [9:0]    x_next;
  logic [9:0]    y_next;
  logic          update;
  logic          in_vis;
  logic          hit;

  assign x_w    = {1'b0, SPRITE_X};
  assign y_w    = {1'b0, SPRITE_Y};
  assign update = (h == H_LAST) && (v == V_UPD);
  assign in_vis = (h < H_VIS) && (v < V_VIS);
  assign hit    = (11'(h) >= x_w) && (11'(h) < x_w + SW) &&
                  (11'(v) >= y_w) && (11'(v) < y_w + SH);

  always_comb begin
    x_next = SPRITE_X;
    y_next = SPRITE_Y;
    if (btn_sync[0] && !btn_sync[1]) begin
      if (x_w + STEP > X_MAX) x_next = X_PAST_HI;
      else                    x_next = 10'(x_w + STEP);
    end else if (btn_sync[1] && !btn_sync[0]) begin
      if (x_w < STEP) x_next = X_PAST_LO;
      else            x_next = 10'(x_w - STEP);
    end
    if (btn_sync[2] && !btn_sync[3]) begin
      if (y_w + STEP > Y_MAX) y_next = Y_PAST_HI;
      else                    y_next = 10'(y_w + STEP);
    end else if (btn_sync[3] && !btn_sync[2]) begin
      if (y_w < STEP) y_next = Y_PAST_LO;
      else            y_next = 10'(y_w - STEP);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      h           <= '0;
      v           <= '0;
      frame_cnt   <= '0;
      btn_meta    <= '0;
      btn_sync    <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      FRAME_START <= 1'b0;
      SPRITE_X    <= X_INIT;
      SPRITE_Y    <= Y_INIT;
    end else begin
      btn_meta <= {BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT};
      btn_sync <= btn_meta;

      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end

      // Outputs are registered from the current counter values, so all lag by one clock together.
      VGA_HS      <= !((h >= HS_BEG) && (h < HS_END));
      VGA_VS      <= !((v >= VS_BEG) && (v < VS_END));
      {VGA_R, VGA_G, VGA_B} <= !in_vis ? '0 : (hit ? FG_RGB : BG_RGB);
      FRAME_START <= (h == '0) && (v == '0);

      if (update) begin
        if (frame_cnt == F_LAST) begin
          frame_cnt <= '0;
          SPRITE_X  <= x_next;
          SPRITE_Y  <= y_next;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule
